// File: rtl/alu_shift_seq_if.sv
// ALU control-line encodings and the request/response + ALU bundle shared by alu_shift_seq
// and whatever sits on the other side of it (decoder and ALU).
package alu_shift_seq_pkg;
    typedef enum logic {R_SH = 1'b0, L_SH = 1'b1} aluSh_e;
    typedef enum logic {RES_OE = 1'b0, SH_OE = 1'b1} aluOe_e;
    typedef enum logic {NO_LD = 1'b0, BUS_LD = 1'b1} aluLd_e;
endpackage

interface alu_shift_seq_if;
    import alu_shift_seq_pkg::*;

    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_op;
    logic [7:0] req_val;
    logic       req_cin;
    logic [2:0] req_cnt;

    logic       done;
    logic [7:0] res;
    logic       flag_z;
    logic       flag_n;
    logic       flag_h;
    logic       flag_c;

    logic [7:0] alu_op;
    logic       alu_si;
    aluSh_e     alu_sh;
    aluOe_e     alu_oe;
    aluLd_e     alu_la;
    aluLd_e     alu_lb;
    logic       alu_r;
    logic       alu_s;
    logic       alu_v;
    logic       alu_ne;
    logic       alu_ci;
    logic       alu_l;
    logic       alu_h;
    logic [7:0] alu_result;
    logic       alu_zero;

    modport slave (
        input  req_valid, req_op, req_val, req_cin, req_cnt, alu_result, alu_zero,
        output req_ready, done, res, flag_z, flag_n, flag_h, flag_c,
               alu_op, alu_si, alu_sh, alu_oe, alu_la, alu_lb,
               alu_r, alu_s, alu_v, alu_ne, alu_ci, alu_l, alu_h
    );

    modport master (
        output req_valid, req_op, req_val, req_cin, req_cnt, alu_result, alu_zero,
        input  req_ready, done, res, flag_z, flag_n, flag_h, flag_c,
               alu_op, alu_si, alu_sh, alu_oe, alu_la, alu_lb,
               alu_r, alu_s, alu_v, alu_ne, alu_ci, alu_l, alu_h
    );
endinterface

// File: rtl/alu_shift_seq.sv
// CB-prefix rotate/shift sequencer: drives an ALU LOAD/RESULT line pair per pass and returns result + flags.
// Define ALU_SEQ_MULTI_EN to honour req_cnt as a 1..8 pass count; otherwise every shift is a single pass.
module alu_shift_seq
    import alu_shift_seq_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    alu_shift_seq_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, RESULT, SWAP, DONE} state_e;

    localparam logic [2:0] OP_RLC  = 3'd0;
    localparam logic [2:0] OP_RRC  = 3'd1;
    localparam logic [2:0] OP_RL   = 3'd2;
    localparam logic [2:0] OP_RR   = 3'd3;
    localparam logic [2:0] OP_SLA  = 3'd4;
    localparam logic [2:0] OP_SRA  = 3'd5;
    localparam logic [2:0] OP_SWAP = 3'd6;

    function automatic logic isLeft(input logic [2:0] op);
        return (op == OP_RLC) || (op == OP_RL) || (op == OP_SLA);
    endfunction

    function automatic logic shiftIn(input logic [2:0] op, input logic [7:0] v, input logic cin);
        case (op)
            OP_RLC, OP_SRA: return v[7];
            OP_RRC:         return v[0];
            OP_RL, OP_RR:   return cin;
            default:        return 1'b0;
        endcase
    endfunction

    state_e     state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [7:0] operand_q, operand_d;
    logic       carry_q, carry_d;
    logic [3:0] passes_q, passes_d;
    logic       done_q, done_d;
    logic [7:0] res_q, res_d;
    logic       z_q, z_d;
    logic       c_q, c_d;
    aluLd_e     ld_q, ld_d;
    aluOe_e     oe_q, oe_d;
    aluSh_e     sh_q, sh_d;
    logic       si_q, si_d;
    logic [7:0] aluOp_q, aluOp_d;
    logic       rsv_q, rsv_d;
    logic       l_q, l_d;
    logic       h_q, h_d;

    logic       goLoad;
    logic [2:0] loadOp;
    logic [7:0] loadVal;
    logic       loadCin;
    logic [7:0] swapped;

    // Every output line is registered: the line for the next state is chosen here.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        operand_d = operand_q;
        carry_d   = carry_q;
        passes_d  = passes_q;
        res_d     = res_q;
        z_d       = z_q;
        c_d       = c_q;
        done_d    = 1'b0;
        ld_d      = NO_LD;
        oe_d      = RES_OE;
        sh_d      = R_SH;
        si_d      = 1'b0;
        aluOp_d   = 8'h00;
        rsv_d     = 1'b0;
        l_d       = 1'b0;
        h_d       = 1'b0;
        goLoad    = 1'b0;
        loadOp    = op_q;
        loadVal   = operand_q;
        loadCin   = carry_q;
        swapped   = {operand_q[3:0], operand_q[7:4]};

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    op_d      = bus.req_op;
                    operand_d = bus.req_val;
                    carry_d   = bus.req_cin;
`ifdef ALU_SEQ_MULTI_EN
                    passes_d  = (bus.req_cnt == 3'd0) ? 4'd8 : {1'b0, bus.req_cnt};
`else
                    passes_d  = 4'd1;
`endif
                    if (bus.req_op == OP_SWAP) begin
                        state_d = SWAP;
                    end else begin
                        goLoad  = 1'b1;
                        loadOp  = bus.req_op;
                        loadVal = bus.req_val;
                        loadCin = bus.req_cin;
                    end
                end
            end
            LOAD: begin
                carry_d = isLeft(op_q) ? operand_q[7] : operand_q[0];
                rsv_d   = 1'b1;
                h_d     = 1'b1;
                state_d = RESULT;
            end
            RESULT: begin
                // Further passes feed the ALU output straight back in as the next operand.
                if (passes_q > 4'd1) begin
                    passes_d  = passes_q - 4'd1;
                    operand_d = bus.alu_result;
                    goLoad    = 1'b1;
                    loadVal   = bus.alu_result;
                end else begin
                    res_d   = bus.alu_result;
                    z_d     = bus.alu_zero;
                    c_d     = carry_q;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            SWAP: begin
                res_d   = swapped;
                z_d     = (swapped == 8'h00);
                c_d     = 1'b0;
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (goLoad) begin
            state_d = LOAD;
            ld_d    = BUS_LD;
            oe_d    = SH_OE;
            sh_d    = isLeft(loadOp) ? L_SH : R_SH;
            si_d    = shiftIn(loadOp, loadVal, loadCin);
            aluOp_d = loadVal;
            rsv_d   = 1'b1;
            l_d     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= 3'd0;
            operand_q <= 8'h00;
            carry_q   <= 1'b0;
            passes_q  <= 4'd1;
            done_q    <= 1'b0;
            res_q     <= 8'h00;
            z_q       <= 1'b0;
            c_q       <= 1'b0;
            ld_q      <= NO_LD;
            oe_q      <= RES_OE;
            sh_q      <= R_SH;
            si_q      <= 1'b0;
            aluOp_q   <= 8'h00;
            rsv_q     <= 1'b0;
            l_q       <= 1'b0;
            h_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            operand_q <= operand_d;
            carry_q   <= carry_d;
            passes_q  <= passes_d;
            done_q    <= done_d;
            res_q     <= res_d;
            z_q       <= z_d;
            c_q       <= c_d;
            ld_q      <= ld_d;
            oe_q      <= oe_d;
            sh_q      <= sh_d;
            si_q      <= si_d;
            aluOp_q   <= aluOp_d;
            rsv_q     <= rsv_d;
            l_q       <= l_d;
            h_q       <= h_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.done      = done_q;
    assign bus.res       = res_q;
    assign bus.flag_z    = z_q;
    assign bus.flag_n    = 1'b0;
    assign bus.flag_h    = 1'b0;
    assign bus.flag_c    = c_q;
    assign bus.alu_op    = aluOp_q;
    assign bus.alu_si    = si_q;
    assign bus.alu_sh    = sh_q;
    assign bus.alu_oe    = oe_q;
    assign bus.alu_la    = ld_q;
    assign bus.alu_lb    = ld_q;
    assign bus.alu_r     = rsv_q;
    assign bus.alu_s     = rsv_q;
    assign bus.alu_v     = rsv_q;
    assign bus.alu_ne    = 1'b0;
    assign bus.alu_ci    = 1'b0;
    assign bus.alu_l     = l_q;
    assign bus.alu_h     = h_q;
endmodule

// File: tb/tb_alu_shift_seq.sv
// Self-checking bench for alu_shift_seq: a simple ALU stand-in answers the control lines and an
// arithmetic reference model of the CB rotate/shift ops supplies every expected result.
module tb_alu_shift_seq;
    import alu_shift_seq_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checkCount = 0;
    int passCount = 0;
    logic [7:0] loadOps[$];

    localparam logic [9:0] QUIET     = {NO_LD, NO_LD, RES_OE, 7'b0000000};
    localparam logic [9:0] LOAD_LINE = {BUS_LD, BUS_LD, SH_OE, 7'b1110010};
    localparam logic [9:0] RES_LINE  = {NO_LD, NO_LD, RES_OE, 7'b1110001};

    alu_shift_seq_if ifc ();

    alu_shift_seq dut (
        .clk  (clk),
        .reset(reset),
        .bus  (ifc.slave)
    );

    always #5 clk = ~clk;

    // ALU stand-in: latches operand/shift-in on a BUS_LD edge and presents the shifted value afterwards.
    logic [7:0] aluA = 8'h00;
    logic       aluSiL = 1'b0;
    logic       aluLeft = 1'b0;
    always @(posedge clk) begin
        if (ifc.alu_la == BUS_LD) begin
            aluA    <= ifc.alu_op;
            aluSiL  <= ifc.alu_si;
            aluLeft <= (ifc.alu_sh == L_SH);
        end
    end
    assign ifc.alu_result = aluLeft ? {aluA[6:0], aluSiL} : {aluSiL, aluA[7:1]};
    assign ifc.alu_zero   = (ifc.alu_result == 8'h00);

    function automatic logic [9:0] lineBits();
        return {ifc.alu_la, ifc.alu_lb, ifc.alu_oe, ifc.alu_r, ifc.alu_s, ifc.alu_v,
                ifc.alu_ne, ifc.alu_ci, ifc.alu_l, ifc.alu_h};
    endfunction

    function automatic int passesFor(input int cnt);
`ifdef ALU_SEQ_MULTI_EN
        return (cnt == 0) ? 8 : cnt;
`else
        return 1;
`endif
    endfunction

    // Reference model: the rotate/shift rules written as integer arithmetic, n passes.
    function automatic void refModel(input int op, input int val, input int cin, input int n,
                                     output int res, output int c);
        int v;
        int cy;
        int hi;
        int lo;
        v  = val;
        cy = cin;
        c  = 0;
        if (op == 6) begin
            res = (val % 16) * 16 + val / 16;
            return;
        end
        for (int p = 0; p < n; p++) begin
            hi = v / 128;
            lo = v % 2;
            case (op)
                0:       begin c = hi; v = (v * 2) % 256 + hi;       end
                1:       begin c = lo; v = v / 2 + lo * 128;         end
                2:       begin c = hi; v = (v * 2) % 256 + cy;       end
                3:       begin c = lo; v = v / 2 + cy * 128;         end
                4:       begin c = hi; v = (v * 2) % 256;            end
                5:       begin c = lo; v = v / 2 + hi * 128;         end
                default: begin c = lo; v = v / 2;                    end
            endcase
            cy = c;
        end
        res = v;
    endfunction

    // Issues one request from an IDLE cycle and returns the done latency (-1 on timeout).
    task automatic runOp(input logic [2:0] op, input logic [7:0] val, input logic cin,
                         input logic [2:0] cnt, output int lat, output int loads,
                         output logic doneAfter);
        lat = -1;
        loads = 0;
        doneAfter = 1'b1;
        loadOps.delete();
        ifc.req_op    = op;
        ifc.req_val   = val;
        ifc.req_cin   = cin;
        ifc.req_cnt   = cnt;
        ifc.req_valid = 1'b1;
        @(posedge clk); #1;
        ifc.req_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (ifc.alu_la == BUS_LD) begin
                loads++;
                loadOps.push_back(ifc.alu_op);
            end
            if (ifc.done === 1'b1) begin
                lat = k;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        doneAfter = ifc.done;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkCount++; if (ifc.req_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b want 1", ifc.req_ready); else passCount++;
        checkCount++; if (ifc.done !== 1'b0) $display("[TB] FAIL reset_done: got %b want 0", ifc.done); else passCount++;
        checkCount++; if (ifc.res !== 8'h00) $display("[TB] FAIL reset_res: got %h want 00", ifc.res); else passCount++;
        checkCount++; if ({ifc.flag_z, ifc.flag_n, ifc.flag_h, ifc.flag_c} !== 4'b0000)
            $display("[TB] FAIL reset_flags: got %b want 0000", {ifc.flag_z, ifc.flag_n, ifc.flag_h, ifc.flag_c}); else passCount++;
        checkCount++; if (lineBits() !== QUIET) $display("[TB] FAIL reset_line: got %b want %b", lineBits(), QUIET); else passCount++;
        checkCount++; if ({ifc.alu_op, ifc.alu_si, ifc.alu_sh} !== {8'h00, 1'b0, R_SH})
            $display("[TB] FAIL reset_bus: got %h/%b/%b want 00/0/R_SH", ifc.alu_op, ifc.alu_si, ifc.alu_sh); else passCount++;
        reset = 1'b0;
        @(posedge clk); #1;
        checkCount++; if ({ifc.done, ifc.req_ready} !== 2'b01) $display("[TB] FAIL idle_after_reset: got %b want 01", {ifc.done, ifc.req_ready}); else passCount++;
    endtask

    task automatic test_sra_lines();
        ifc.req_op = 3'd5; ifc.req_val = 8'h81; ifc.req_cin = 1'b0; ifc.req_cnt = 3'd1; ifc.req_valid = 1'b1;
        @(posedge clk); #1;
        ifc.req_valid = 1'b0;
        checkCount++; if (lineBits() !== LOAD_LINE) $display("[TB] FAIL sra_load_line: got %b want %b", lineBits(), LOAD_LINE); else passCount++;
        checkCount++; if ({ifc.alu_op, ifc.alu_si, ifc.alu_sh} !== {8'h81, 1'b1, R_SH})
            $display("[TB] FAIL sra_load_bus: got %h/%b/%b want 81/1/R_SH", ifc.alu_op, ifc.alu_si, ifc.alu_sh); else passCount++;
        checkCount++; if ({ifc.req_ready, ifc.done} !== 2'b00) $display("[TB] FAIL sra_load_busy: got %b want 00", {ifc.req_ready, ifc.done}); else passCount++;
        @(posedge clk); #1;
        checkCount++; if (lineBits() !== RES_LINE) $display("[TB] FAIL sra_result_line: got %b want %b", lineBits(), RES_LINE); else passCount++;
        checkCount++; if (ifc.done !== 1'b0) $display("[TB] FAIL sra_early_done: got %b want 0", ifc.done); else passCount++;
        @(posedge clk); #1;
        checkCount++; if (ifc.done !== 1'b1) $display("[TB] FAIL sra_done_t3: got %b want 1", ifc.done); else passCount++;
        checkCount++; if ({ifc.res, ifc.flag_z, ifc.flag_n, ifc.flag_h, ifc.flag_c} !== {8'hC0, 4'b0001})
            $display("[TB] FAIL sra_result: got %h z%b n%b h%b c%b want C0 z0 n0 h0 c1",
                     ifc.res, ifc.flag_z, ifc.flag_n, ifc.flag_h, ifc.flag_c); else passCount++;
        checkCount++; if (lineBits() !== QUIET) $display("[TB] FAIL done_line_quiet: got %b want %b", lineBits(), QUIET); else passCount++;
        @(posedge clk); #1;
        checkCount++; if ({ifc.done, ifc.req_ready, ifc.res} !== {2'b01, 8'hC0})
            $display("[TB] FAIL sra_after_done: got done%b ready%b res%h want done0 ready1 resC0", ifc.done, ifc.req_ready, ifc.res); else passCount++;
    endtask

    task automatic test_directed();
        int lat;
        int loads;
        logic doneAfter;
        runOp(3'd7, 8'h01, 1'b0, 3'd1, lat, loads, doneAfter);
        checkCount++; if ({ifc.res, ifc.flag_z, ifc.flag_c} !== {8'h00, 2'b11})
            $display("[TB] FAIL srl_01: got %h z%b c%b want 00 z1 c1", ifc.res, ifc.flag_z, ifc.flag_c); else passCount++;
        checkCount++; if (lat !== 3) $display("[TB] FAIL srl_latency: got %0d want 3", lat); else passCount++;
        checkCount++; if (doneAfter !== 1'b0) $display("[TB] FAIL srl_done_width: got %b want 0", doneAfter); else passCount++;
        runOp(3'd2, 8'h80, 1'b0, 3'd1, lat, loads, doneAfter);
        checkCount++; if ({ifc.res, ifc.flag_z, ifc.flag_c} !== {8'h00, 2'b11})
            $display("[TB] FAIL rl_80: got %h z%b c%b want 00 z1 c1", ifc.res, ifc.flag_z, ifc.flag_c); else passCount++;
        runOp(3'd6, 8'hA5, 1'b1, 3'd3, lat, loads, doneAfter);
        checkCount++; if ({ifc.res, ifc.flag_z, ifc.flag_c} !== {8'h5A, 2'b00})
            $display("[TB] FAIL swap_a5: got %h z%b c%b want 5A z0 c0", ifc.res, ifc.flag_z, ifc.flag_c); else passCount++;
        checkCount++; if (lat !== 2) $display("[TB] FAIL swap_latency: got %0d want 2", lat); else passCount++;
        checkCount++; if (loads !== 0) $display("[TB] FAIL swap_bus_ld: got %0d cycles want 0", loads); else passCount++;
    endtask

    task automatic test_back_to_back();
        int busyReady;
        logic readyAt4;
        int doneAt[$];
        logic [7:0] res3;
        logic [7:0] res7;
        logic c7;
        busyReady = 0;
        readyAt4 = 1'b0;
        res3 = 8'h00;
        res7 = 8'h00;
        c7 = 1'b0;
        ifc.req_op = 3'd5; ifc.req_val = 8'h81; ifc.req_cin = 1'b0; ifc.req_cnt = 3'd1; ifc.req_valid = 1'b1;
        @(posedge clk); #1;
        // The decoder keeps valid high and presents the next instruction while the first one is busy.
        ifc.req_op = 3'd0; ifc.req_val = 8'h81;
        for (int k = 1; k <= 12; k++) begin
            if (k == 5) ifc.req_valid = 1'b0;
            if (k <= 3 && ifc.req_ready !== 1'b0) busyReady++;
            if (k == 4) readyAt4 = ifc.req_ready;
            if (ifc.done === 1'b1) begin
                doneAt.push_back(k);
                if (k == 3) res3 = ifc.res;
                if (k == 7) begin res7 = ifc.res; c7 = ifc.flag_c; end
            end
            @(posedge clk); #1;
        end
        checkCount++; if (busyReady !== 0) $display("[TB] FAIL b2b_ready_busy: got %0d high cycles want 0", busyReady); else passCount++;
        checkCount++; if (readyAt4 !== 1'b1) $display("[TB] FAIL b2b_ready_idle: got %b want 1", readyAt4); else passCount++;
        checkCount++; if (doneAt.size() !== 2) $display("[TB] FAIL b2b_done_count: got %0d want 2", doneAt.size()); else passCount++;
        checkCount++; if ((doneAt.size() > 0 ? doneAt[0] : -1) !== 3)
            $display("[TB] FAIL b2b_first_done: got %0d want 3", doneAt.size() > 0 ? doneAt[0] : -1); else passCount++;
        checkCount++; if ((doneAt.size() > 1 ? doneAt[1] : -1) !== 7)
            $display("[TB] FAIL b2b_second_done: got %0d want 7", doneAt.size() > 1 ? doneAt[1] : -1); else passCount++;
        checkCount++; if ({res3, res7, c7} !== {8'hC0, 8'h03, 1'b1})
            $display("[TB] FAIL b2b_results: got %h %h c%b want C0 03 c1", res3, res7, c7); else passCount++;
    endtask

    task automatic test_reset_mid_op();
        int dones;
        dones = 0;
        ifc.req_op = 3'd7; ifc.req_val = 8'h02; ifc.req_cin = 1'b0; ifc.req_cnt = 3'd1; ifc.req_valid = 1'b1;
        @(posedge clk); #1;
        ifc.req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkCount++; if (lineBits() !== QUIET) $display("[TB] FAIL midreset_line: got %b want %b", lineBits(), QUIET); else passCount++;
        checkCount++; if ({ifc.done, ifc.req_ready, ifc.res} !== {2'b01, 8'h00})
            $display("[TB] FAIL midreset_state: got done%b ready%b res%h want done0 ready1 res00", ifc.done, ifc.req_ready, ifc.res); else passCount++;
        checkCount++; if ({ifc.flag_z, ifc.flag_c} !== 2'b00) $display("[TB] FAIL midreset_flags: got %b want 00", {ifc.flag_z, ifc.flag_c}); else passCount++;
        for (int k = 0; k < 6; k++) begin
            if (ifc.done !== 1'b0) dones++;
            @(posedge clk); #1;
        end
        checkCount++; if (dones !== 0) $display("[TB] FAIL midreset_no_done: got %0d pulses want 0", dones); else passCount++;
    endtask

    task automatic test_random();
        int op;
        int val;
        int cin;
        int cnt;
        int n;
        int eRes;
        int eC;
        int eLat;
        int lat;
        int loads;
        logic doneAfter;
        for (int i = 0; i < 24; i++) begin
            op  = (i < 8) ? i : int'($urandom_range(0, 7));
            val = int'($urandom_range(0, 255));
            cin = int'($urandom_range(0, 1));
            cnt = int'($urandom_range(0, 7));
            n   = (op == 6) ? 1 : passesFor(cnt);
            refModel(op, val, cin, n, eRes, eC);
            eLat = (op == 6) ? 2 : 1 + 2 * n;
            runOp(3'(op), 8'(val), 1'(cin), 3'(cnt), lat, loads, doneAfter);
            checkCount++; if (ifc.res !== 8'(eRes))
                $display("[TB] FAIL rand_res op%0d val%h cin%0d: got %h want %h", op, val, cin, ifc.res, 8'(eRes)); else passCount++;
            checkCount++; if ({ifc.flag_z, ifc.flag_c} !== {eRes == 0, 1'(eC)})
                $display("[TB] FAIL rand_flags op%0d val%h: got z%b c%b want z%b c%b", op, val, ifc.flag_z, ifc.flag_c, eRes == 0, 1'(eC)); else passCount++;
            checkCount++; if (lat !== eLat) $display("[TB] FAIL rand_latency op%0d: got %0d want %0d", op, lat, eLat); else passCount++;
        end
    endtask

`ifdef ALU_SEQ_MULTI_EN
    task automatic test_multi();
        int lat;
        int loads;
        logic doneAfter;
        runOp(3'd0, 8'h81, 1'b0, 3'd3, lat, loads, doneAfter);
        checkCount++; if (lat !== 7) $display("[TB] FAIL multi_latency: got %0d want 7", lat); else passCount++;
        checkCount++; if ({ifc.res, ifc.flag_z, ifc.flag_c} !== {8'h0C, 2'b00})
            $display("[TB] FAIL multi_result: got %h z%b c%b want 0C z0 c0", ifc.res, ifc.flag_z, ifc.flag_c); else passCount++;
        checkCount++; if (loadOps.size() !== 3 || loadOps[0] !== 8'h81 || loadOps[1] !== 8'h03 || loadOps[2] !== 8'h06)
            $display("[TB] FAIL multi_pass_operands: got %0d loads want 81 03 06", loadOps.size()); else passCount++;
    endtask
`endif

    initial begin
        ifc.req_valid = 1'b0;
        ifc.req_op    = 3'd0;
        ifc.req_val   = 8'h00;
        ifc.req_cin   = 1'b0;
        ifc.req_cnt   = 3'd0;
        test_reset();
        test_sra_lines();
        test_directed();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
`ifdef ALU_SEQ_MULTI_EN
        test_multi();
`endif
        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
